bird_vertical_ctrl: RTL and testbench
=====================================

// Module: bird_vertical_ctrl
// PURPOSE
//  Produces the bird's vertical position and the top/bottom edge-light flags
//  (upLight, downLight) consumed by the edge-death detector.
//  Applies gravity (one row down per FALL_PERIOD cycles) and a flap impulse
//  (FLAP_HEIGHT rows up).
//  Freezes the bird once the detector or a pipe-collision block asserts death.
// PARAMETERS
//  ROWS         8   number of display rows; row 0 = bottom, ROWS-1 = top
//  START_ROW    3   row loaded at reset; must be < ROWS
//  FALL_PERIOD  32  cycles per motion step (gravity or rise); >= 2
//  FLAP_HEIGHT  2   rows gained per flap; >= 1
// PORTS
//  Clock      in   1                    system clock, rising edge
//  Reset      in   1                    async, active-low; 0 = reset
//  start      in   1                    level; begins flight from IDLE
//  flap       in   1                    raw button level; rising edge = flap
//  death      in   1                    level from death detectors
//  birdRow    out  ROWS                 one-hot bird position
//  upLight    out  1                    bird in top row (ROWS-1)
//  downLight  out  1                    bird in bottom row (0)
//  alive      out  1                    state is FLY or RISE
// BEHAVIOUR
//  - Reset (Reset==0, async): state=IDLE, row=START_ROW, stepCnt=0,
//    riseLeft=0, flap-edge history cleared.
//    Hence birdRow=1<<START_ROW, upLight=downLight=alive=0 (for START_ROW
//    interior).
//  - Outputs are decoded combinationally from registered row/state.
//    Output moves in the cycle after the update edge.
//  - Motion step fires when stepCnt==FALL_PERIOD-1:
//    stepCnt wraps to 0; otherwise stepCnt+1.
//    stepCnt runs only in FLY/RISE and is forced to 0 in IDLE/DEAD.
//  - FSM (priority order within each state):
//    IDLE: death -> DEAD; start -> FLY (stepCnt=0); else hold.
//    FLY:  death -> DEAD; flapEdge -> RISE, riseLeft=FLAP_HEIGHT, stepCnt=0;
//          step -> row=max(row-1,0).
//    RISE: death -> DEAD; flapEdge -> riseLeft=FLAP_HEIGHT, stepCnt=0 (re-arm);
//          step -> row=min(row+1,ROWS-1), riseLeft-1;
//          if riseLeft becomes 0 -> FLY.
//    DEAD: absorbing; row, riseLeft, outputs frozen; only Reset exits.
//  - flapEdge = flap & ~flap_q, with flap_q registered every cycle.
//    Holding flap gives one flap; edges in IDLE/DEAD are discarded.
//  - Saturation: row never wraps.
//    At top, RISE steps still decrement riseLeft while row stays ROWS-1.
//    At bottom, FLY keeps row=0 with downLight held.
//  - Simultaneous events:
//    death beats flapEdge/step in the same cycle (row not updated).
//    flapEdge beats step in FLY/RISE (row not updated that cycle).
//  - Reset mid-flight: immediate return to reset values, independent of Clock.
//  - Widths:
//    row and riseLeft are $clog2(ROWS) and $clog2(FLAP_HEIGHT+1) bits.
//    stepCnt is $clog2(FALL_PERIOD) bits.
//    All compares are unsigned.
// STRUCTURE
//  - flappy_pkg: typedef enum {IDLE, FLY, RISE, DEAD} bird_state_t;
//    also holds the ROW_W localparam helper function.
//    edgeLight and the future pipe-collision block share this package.
//  - Sub-module press_edge (flap_q register + rising-edge detect).
//    Reused later for the start button.
//  - Remainder: one always_ff (async reset), one always_comb next-state,
//    one output decode.
// TESTING (ROWS=8, START_ROW=3, FALL_PERIOD=4, FLAP_HEIGHT=2)
//  1. Reset low then high, no start, 20 cycles
//     -> birdRow=8'h08, alive=0, row constant.
//  2. start pulse, no flap
//     -> row 3,2,1,0, one step every 4 cycles.
//     -> downLight=1 from row 0; row holds at 0 for 20 more cycles.
//  3. From row 3 in FLY, flap held high 12 cycles
//     -> exactly one flap, row 4 then 5, then gravity resumes to 4.
//  4. Row 6, flap then second flap at the first rise step
//     -> row 7 with upLight=1; extra step saturates at 7; then falls to 6.
//  5. death and flap asserted in the same cycle while in FLY at row 5
//     -> DEAD, birdRow=8'h20 frozen, alive=0, later flap/start ignored.
//  6. Reset pulled low mid-RISE, asynchronously between edges
//     -> outputs return to birdRow=8'h08, alive=0 before the next Clock edge.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared types and width helpers for the flappy game blocks.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    RISE = 2'd2,
    DEAD = 2'd3
  } bird_state_t;

  // Bits needed to index n values, never less than one.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/press_edge.sv
// Registers a raw button level and flags its rising edge for one cycle.
module press_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_c_o
);

  logic btn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_q <= 1'b0;
    else        btn_q <= btn_i;
  end

  assign press_c_o = btn_i & ~btn_q;

endmodule

// File: rtl/bird_vertical_ctrl.sv
// Bird vertical motion: gravity, flap impulse, death freeze and edge lights.
module bird_vertical_ctrl
  import flappy_pkg::*;
#(
  parameter int unsigned ROWS        = 8,
  parameter int unsigned START_ROW   = 3,
  parameter int unsigned FALL_PERIOD = 32,
  parameter int unsigned FLAP_HEIGHT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            flap_i,
  input  logic            death_i,
  output logic [ROWS-1:0] bird_row_o,
  output logic            up_light_o,
  output logic            down_light_o,
  output logic            alive_o
);

  localparam int unsigned ROW_W  = width_of(ROWS);
  localparam int unsigned RISE_W = width_of(FLAP_HEIGHT + 1);
  localparam int unsigned CNT_W  = width_of(FALL_PERIOD);

  localparam logic [ROW_W-1:0]  ROW_TOP   = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0]  ROW_START = ROW_W'(START_ROW);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FALL_PERIOD - 1);
  localparam logic [RISE_W-1:0] RISE_FULL = RISE_W'(FLAP_HEIGHT);

  bird_state_t       state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [RISE_W-1:0] rise_q, rise_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              flap_edge;
  logic              step;

  press_edge u_flap_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_i     (flap_i),
    .press_c_o (flap_edge)
  );

  assign step = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= ROW_START;
      rise_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; death wins over flap, and flap wins over a motion step.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    rise_d  = rise_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (death_i)      state_d = DEAD;
        else if (start_i) state_d = FLY;
      end
      FLY: begin
        cnt_d = step ? '0 : cnt_q + CNT_W'(1);
        if (death_i) begin
          state_d = DEAD;
          cnt_d   = '0;
        end else if (flap_edge) begin
          state_d = RISE;
          rise_d  = RISE_FULL;
          cnt_d   = '0;
        end else if (step) begin
          row_d = (row_q == '0) ? row_q : row_q - ROW_W'(1);
        end
      end
      RISE: begin
        cnt_d = step ? '0 : cnt_q + CNT_W'(1);
        if (death_i) begin
          state_d = DEAD;
          cnt_d   = '0;
        end else if (flap_edge) begin
          rise_d = RISE_FULL;
          cnt_d  = '0;
        end else if (step) begin
          row_d  = (row_q == ROW_TOP) ? row_q : row_q + ROW_W'(1);
          rise_d = rise_q - RISE_W'(1);
          if (rise_q == RISE_W'(1)) state_d = FLY;
        end
      end
      default: state_d = DEAD;
    endcase
  end

  always_comb begin
    bird_row_o   = ROWS'(1) << row_q;
    up_light_o   = (row_q == ROW_TOP);
    down_light_o = (row_q == '0);
    alive_o      = (state_q == FLY) || (state_q == RISE);
  end

endmodule

// File: tb/tb_bird_vertical_ctrl.sv
// Directed bench for bird_vertical_ctrl with a short motion period.
module tb_bird_vertical_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i;
  logic       flap_i;
  logic       death_i;
  logic [7:0] bird_row_o;
  logic       up_light_o;
  logic       down_light_o;
  logic       alive_o;

  int checks = 0;
  int errors = 0;

  bird_vertical_ctrl #(
    .ROWS        (8),
    .START_ROW   (3),
    .FALL_PERIOD (4),
    .FLAP_HEIGHT (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .flap_i       (flap_i),
    .death_i      (death_i),
    .bird_row_o   (bird_row_o),
    .up_light_o   (up_light_o),
    .down_light_o (down_light_o),
    .alive_o      (alive_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start_i = 1'b0; flap_i = 1'b0; death_i = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic do_start();
    start_i = 1'b1;
    cyc(1);
    start_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start_i = 1'b0; flap_i = 1'b0; death_i = 1'b0;
    cyc(2);
    check("rst_row", 32'(bird_row_o), 32'h08);
    check("rst_alive", 32'(alive_o), 32'd0);
    check("rst_up", 32'(up_light_o), 32'd0);
    check("rst_down", 32'(down_light_o), 32'd0);
    rst_n = 1'b1;

    // 1: idle without start holds the start row
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      check("idle_row", 32'(bird_row_o), 32'h08);
    end
    check("idle_alive", 32'(alive_o), 32'd0);

    // 2: gravity only
    do_start();
    check("fly_alive", 32'(alive_o), 32'd1);
    check("fly_row3_a", 32'(bird_row_o), 32'h08);
    cyc(3);
    check("fly_row3_b", 32'(bird_row_o), 32'h08);
    cyc(1);
    check("fly_row2", 32'(bird_row_o), 32'h04);
    cyc(4);
    check("fly_row1", 32'(bird_row_o), 32'h02);
    check("fly_down_off", 32'(down_light_o), 32'd0);
    cyc(4);
    check("fly_row0", 32'(bird_row_o), 32'h01);
    check("fly_down_on", 32'(down_light_o), 32'd1);
    cyc(20);
    check("fly_floor_row", 32'(bird_row_o), 32'h01);
    check("fly_floor_down", 32'(down_light_o), 32'd1);
    check("fly_floor_alive", 32'(alive_o), 32'd1);

    // 3: held flap gives one impulse of two rows
    do_reset();
    do_start();
    flap_i = 1'b1;
    cyc(1);
    check("hold_edge_row", 32'(bird_row_o), 32'h08);
    cyc(3);
    check("hold_pre_step", 32'(bird_row_o), 32'h08);
    cyc(1);
    check("hold_row4", 32'(bird_row_o), 32'h10);
    cyc(4);
    check("hold_row5", 32'(bird_row_o), 32'h20);
    cyc(3);
    flap_i = 1'b0;
    cyc(1);
    check("hold_fall_row4", 32'(bird_row_o), 32'h10);

    // climb from row 4 to row 6
    flap_i = 1'b1;
    cyc(1);
    flap_i = 1'b0;
    cyc(8);
    check("climb_row6", 32'(bird_row_o), 32'h40);

    // 4: re-flap on the step edge, then saturate at the top
    flap_i = 1'b1;
    cyc(1);
    flap_i = 1'b0;
    cyc(3);
    flap_i = 1'b1;
    cyc(1);
    check("reflap_no_step", 32'(bird_row_o), 32'h40);
    flap_i = 1'b0;
    cyc(4);
    check("top_row7", 32'(bird_row_o), 32'h80);
    check("top_up_on", 32'(up_light_o), 32'd1);
    cyc(4);
    check("top_sat_row7", 32'(bird_row_o), 32'h80);
    check("top_sat_alive", 32'(alive_o), 32'd1);
    cyc(4);
    check("top_fall_row6", 32'(bird_row_o), 32'h40);
    check("top_up_off", 32'(up_light_o), 32'd0);
    cyc(4);
    check("fall_row5", 32'(bird_row_o), 32'h20);

    // 5: death beats flap, then everything is frozen
    death_i = 1'b1;
    flap_i = 1'b1;
    cyc(1);
    check("dead_row", 32'(bird_row_o), 32'h20);
    check("dead_alive", 32'(alive_o), 32'd0);
    death_i = 1'b0;
    flap_i = 1'b0;
    cyc(2);
    flap_i = 1'b1;
    cyc(1);
    flap_i = 1'b0;
    start_i = 1'b1;
    cyc(10);
    start_i = 1'b0;
    check("dead_frozen_row", 32'(bird_row_o), 32'h20);
    check("dead_frozen_alive", 32'(alive_o), 32'd0);

    // 6: asynchronous reset mid-rise
    do_reset();
    do_start();
    flap_i = 1'b1;
    cyc(1);
    flap_i = 1'b0;
    cyc(5);
    check("pre_areset_row", 32'(bird_row_o), 32'h10);
    check("pre_areset_alive", 32'(alive_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_row", 32'(bird_row_o), 32'h08);
    check("areset_alive", 32'(alive_o), 32'd0);
    cyc(1);
    rst_n = 1'b1;
    cyc(3);
    check("post_areset_row", 32'(bird_row_o), 32'h08);
    check("post_areset_alive", 32'(alive_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
